// File: rtl/data_memory_sized_if.sv
// Load/store request and completion bus of the sized data memory.
interface data_memory_sized_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              req;
  logic              WE;
  logic [1:0]        size;
  logic              uns;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] WriDat;
  logic [DWIDTH-1:0] ReaDat;
  logic              valid;
  logic              ready;
  logic              err;

  modport master (
    output req, WE, size, uns, addr, WriDat,
    input  ReaDat, valid, ready, err
  );

  modport slave (
    input  req, WE, size, uns, addr, WriDat,
    output ReaDat, valid, ready, err
  );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with sized, extended loads and zeroing after reset.
// Latency 1 cycle, one access per cycle; ready stays low for DEPTH cycles while clearing.
module data_memory_sized #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 128,
  parameter int AWIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  data_memory_sized_if.slave bus
);
  localparam int LANES = DWIDTH / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam logic [AWIDTH:0] MEMBYTES = (AWIDTH+1)'(DEPTH * LANES);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [IDXW-1:0]   cnt;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdat_q;
  logic              valid_q;
  logic              err_q;
  logic              ready_q;

  logic [IDXW-1:0]   idx;
  logic [OFFW-1:0]   off;
  logic [3:0]        off_n;
  logic [3:0]        nb;
  logic              illegal;
  logic [LANES-1:0]  be;
  logic [DWIDTH-1:0] wsh;
  logic [DWIDTH-1:0] rsh;
  logic [DWIDTH-1:0] lowmask;
  logic              sbit;
  logic [DWIDTH-1:0] ld_dat;

  assign idx = bus.addr[OFFW +: IDXW];
  assign off = bus.addr[OFFW-1:0];

  always_comb begin
    nb      = 4'd1 << bus.size;
    off_n   = 4'(off);
    illegal = ({1'b0, bus.addr} >= MEMBYTES)
            | ((bus.size == 2'b01) && bus.addr[0])
            | ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00))
            | ((bus.size == 2'b11) && ((DWIDTH == 32) || (bus.addr[2:0] != 3'b000)));
    wsh     = bus.WriDat << {off, 3'b000};
    rsh     = mem[idx] >> {off, 3'b000};
    be      = '0;
    lowmask = '0;
    sbit    = 1'b0;
    // Aligned accesses never straddle a word, so lane enables are a contiguous window.
    for (int l = 0; l < LANES; l++) begin
      be[l]            = (4'(l) >= off_n) && (4'(l) < off_n + nb);
      lowmask[8*l +: 8] = (4'(l) < nb) ? 8'hFF : 8'h00;
      if (4'(l) == nb - 4'd1) sbit = rsh[8*l+7];
    end
    ld_dat = (rsh & lowmask) | ((sbit && !bus.uns) ? ~lowmask : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          mem[cnt] <= '0;
          cnt      <= cnt + IDXW'(1);
          valid_q  <= 1'b0;
          err_q    <= 1'b0;
          if (cnt == IDXW'(DEPTH-1)) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        IDLE: begin
          valid_q <= bus.req;
          err_q   <= bus.req & illegal;
          if (bus.req) begin
            if (illegal) begin
              rdat_q <= '0;
            end else if (bus.WE) begin
              for (int l = 0; l < LANES; l++) begin
                if (be[l]) mem[idx][8*l +: 8] <= wsh[8*l +: 8];
              end
            end else begin
              rdat_q <= ld_dat;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.ReaDat = rdat_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.ready  = ready_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: directed scenarios plus random traffic against a byte-array model.
module tb_data_memory_sized;
  localparam int DW     = 32;
  localparam int DP     = 128;
  localparam int AW     = 32;
  localparam int LN     = DW / 8;
  localparam int NBYTES = DP * LN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_sized_if #(.DWIDTH(DW), .AWIDTH(AW)) bus();
  data_memory_sized #(.DWIDTH(DW), .DEPTH(DP), .AWIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]    mb [NBYTES];
  logic [DW-1:0] exp_rd;
  logic          exp_err;

  function automatic bit m_bad(input logic [1:0] sz, input logic [AW-1:0] a);
    int n;
    n = 1 << sz;
    if (a >= NBYTES) return 1'b1;
    if (n > LN) return 1'b1;
    if (a % n != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_load(input logic [1:0] sz, input logic u, input logic [AW-1:0] a);
    logic [63:0] v;
    int n;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a+i];
    if (!u && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v[DW-1:0];
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < (1 << sz); i++) mb[a+i] = d[8*i +: 8];
  endtask

  task automatic m_clear();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    exp_rd = '0;
  endtask

  task automatic drive(input bit we, input logic [1:0] sz, input bit u, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.req = 1'b1; bus.WE = we; bus.size = sz; bus.uns = u; bus.addr = a; bus.WriDat = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted access; the model is advanced to what the completion should show.
  task automatic access(input bit we, input logic [1:0] sz, input bit u, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    exp_err = m_bad(sz, a);
    if (exp_err) exp_rd = '0;
    else if (we) m_store(sz, a, d);
    else exp_rd = m_load(sz, u, a);
    drive(we, sz, u, a, d);
    step();
    bus.req = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    bus.req = 1'b0;
    repeat (2) step();
    total++;
    if ({bus.ready, bus.valid, bus.err} !== 3'b000 || bus.ReaDat !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy/vld/err=%b rd=%h want 000 0",
               {bus.ready, bus.valid, bus.err}, bus.ReaDat);
    end
    rst = 1'b0;
    wait_ready(n);
    total++;
    if (n !== DP) begin
      bad++;
      $display("FAIL clear_cycles: got %0d want %0d", n, DP);
    end
    m_clear();
    for (int i = 0; i < DP; i++) begin
      access(1'b0, 2'b10, 1'b1, AW'(i*4), '0);
      total++;
      if (bus.valid !== 1'b1 || bus.err !== 1'b0 || bus.ReaDat !== '0) begin
        bad++;
        $display("FAIL cleared_word[%0d]: got v=%b e=%b rd=%h want 1 0 0", i, bus.valid, bus.err, bus.ReaDat);
      end
    end
  endtask

  task automatic test_byte_lanes();
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    total++;
    if (bus.valid !== 1'b1 || bus.err !== 1'b0 || bus.ReaDat !== exp_rd) begin
      bad++;
      $display("FAIL store_word: got v=%b e=%b rd=%h want 1 0 %h", bus.valid, bus.err, bus.ReaDat, exp_rd);
    end
    access(1'b1, 2'b00, 1'b0, 32'h12, 32'h555555AA);
    access(1'b0, 2'b10, 1'b0, 32'h10, '0);
    total++;
    if (bus.ReaDat !== 32'h11AA3344 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL byte_lane_merge: got %h want 11aa3344", bus.ReaDat);
    end
  endtask

  task automatic test_extension();
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h000080F0);
    access(1'b0, 2'b01, 1'b0, 32'h20, '0);
    total++;
    if (bus.ReaDat !== 32'hFFFF80F0) begin
      bad++;
      $display("FAIL half_sext: got %h want ffff80f0", bus.ReaDat);
    end
    access(1'b0, 2'b01, 1'b1, 32'h20, '0);
    total++;
    if (bus.ReaDat !== 32'h000080F0) begin
      bad++;
      $display("FAIL half_zext: got %h want 000080f0", bus.ReaDat);
    end
    access(1'b0, 2'b00, 1'b0, 32'h21, '0);
    total++;
    if (bus.ReaDat !== 32'hFFFFFF80) begin
      bad++;
      $display("FAIL byte_sext: got %h want ffffff80", bus.ReaDat);
    end
  endtask

  task automatic test_errors();
    logic [AW-1:0] ea [4];
    logic [1:0]    es [4];
    ea = '{32'h31, 32'd512, 32'h30, 32'h32};
    es = '{2'b01, 2'b10, 2'b11, 2'b10};
    access(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D);
    access(1'b0, 2'b10, 1'b0, 32'h30, '0);
    for (int i = 0; i < 4; i++) begin
      access(1'b1, es[i], 1'b0, ea[i], 32'h12345678);
      total++;
      if (bus.valid !== 1'b1 || bus.err !== 1'b1 || bus.ReaDat !== '0) begin
        bad++;
        $display("FAIL illegal_store[%0d]: got v=%b e=%b rd=%h want 1 1 0", i, bus.valid, bus.err, bus.ReaDat);
      end
    end
    access(1'b0, 2'b10, 1'b0, 32'h30, '0);
    total++;
    if (bus.ReaDat !== 32'hCAFEF00D || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL unchanged_after_err: got %h want cafef00d", bus.ReaDat);
    end
    access(1'b1, 2'b10, 1'b0, 32'd508, 32'h0BADCAFE);
    access(1'b0, 2'b10, 1'b0, 32'd508, '0);
    total++;
    if (bus.err !== 1'b0 || bus.ReaDat !== 32'h0BADCAFE) begin
      bad++;
      $display("FAIL last_word: got e=%b rd=%h want 0 0badcafe", bus.err, bus.ReaDat);
    end
  endtask

  task automatic test_back_to_back();
    m_store(2'b10, 32'h40, 32'hDEADBEEF);
    drive(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    step();
    total++;
    if (bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_store_valid: got %b want 1", bus.valid);
    end
    drive(1'b0, 2'b10, 1'b0, 32'h40, '0);
    step();
    bus.req = 1'b0;
    exp_rd = 32'hDEADBEEF;
    total++;
    if (bus.valid !== 1'b1 || bus.ReaDat !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL b2b_load: got v=%b rd=%h want 1 deadbeef", bus.valid, bus.ReaDat);
    end
    step();
    total++;
    if (bus.valid !== 1'b0 || bus.ReaDat !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL idle_after_b2b: got v=%b rd=%h want 0 deadbeef", bus.valid, bus.ReaDat);
    end
  endtask

  task automatic test_random();
    logic [1:0]    sz;
    logic [AW-1:0] a;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req = 1'b0;
        step();
        total++;
        if (bus.valid !== 1'b0 || bus.ReaDat !== exp_rd) begin
          bad++;
          $display("FAIL rnd_idle[%0d]: got v=%b rd=%h want 0 %h", it, bus.valid, bus.ReaDat, exp_rd);
        end
      end else begin
        sz = 2'($urandom_range(0, 3));
        a  = AW'($urandom_range(0, NBYTES + 63));
        if ($urandom_range(0, 3) != 0) a = a & ~(AW'((1 << sz) - 1));
        access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, DW'($urandom));
        total++;
        if (bus.valid !== 1'b1 || bus.err !== exp_err || bus.ReaDat !== exp_rd) begin
          bad++;
          $display("FAIL rnd_access[%0d]: got v=%b e=%b rd=%h want 1 %b %h",
                   it, bus.valid, bus.err, bus.ReaDat, exp_err, exp_rd);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    access(1'b1, 2'b10, 1'b0, 32'd500, 32'hA5A5A5A5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (50) step();
    total++;
    if (bus.ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_mid_clear: got %b want 0", bus.ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(n);
    total++;
    if (n !== DP) begin
      bad++;
      $display("FAIL clear_restart_cycles: got %0d want %0d", n, DP);
    end
    m_clear();
    access(1'b0, 2'b10, 1'b0, 32'd500, '0);
    total++;
    if (bus.ReaDat !== '0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL cleared_after_restart: got %h want 0", bus.ReaDat);
    end
    access(1'b1, 2'b10, 1'b0, 32'h44, 32'h13572468);
    drive(1'b0, 2'b10, 1'b0, 32'h44, '0);
    step();
    bus.req = 1'b0;
    rst = 1'b1;
    step();
    total++;
    if (bus.valid !== 1'b0 || bus.err !== 1'b0 || bus.ReaDat !== '0 || bus.ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_discards_load: got v=%b e=%b rd=%h rdy=%b want 0 0 0 0",
               bus.valid, bus.err, bus.ReaDat, bus.ready);
    end
    rst = 1'b0;
    wait_ready(n);
    m_clear();
    access(1'b0, 2'b10, 1'b0, 32'h44, '0);
    total++;
    if (n !== DP || bus.ReaDat !== '0) begin
      bad++;
      $display("FAIL clear_after_access_reset: got n=%0d rd=%h want %0d 0", n, bus.ReaDat, DP);
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.WE = 1'b0; bus.size = 2'b00; bus.uns = 1'b0; bus.addr = '0; bus.WriDat = '0;
    exp_rd = '0;
    exp_err = 1'b0;
    test_reset();
    test_byte_lanes();
    test_extension();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
